// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types (word, register index, hazard FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } hzstate_t;

   localparam word_t c_word_max = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Flags an ID-stage read of a register an EX-stage load is writing.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic     memread_ex,
   input  regbits_t rd_ex,
   input  regbits_t rs_id,
   input  regbits_t rt_id,
   output logic     luse
);

   // r0 is hardwired to zero, so a load targeting it can never create a hazard
   assign luse = memread_ex && (rd_ex != 5'd0) && ((rd_ex == rs_id) || (rd_ex == rt_id));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush/halt control; HAZARD_CTRL_PERF_EN adds
//            saturating stall and flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     dREN_mem,
   input  logic     dWEN_mem,
   input  logic     memread_ex,
   input  regbits_t rd_ex,
   input  regbits_t rs_id,
   input  regbits_t rt_id,
   input  logic     brtaken_ex,
   input  logic     halt_wb,
   output logic     pc_en,
   output logic     ifid_en,
   output logic     ifid_flush,
   output logic     idex_en,
   output logic     idex_flush,
   output logic     exmem_en,
   output logic     exmem_flush,
   output logic     memwb_en,
   output logic     halted
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output word_t    stall_cnt,
   output word_t    flush_cnt
`endif
);

   hzstate_t r_state, w_state_nxt;
   logic     r_flush_pend, w_flush_pend_nxt;
   logic     w_dreq, w_dmiss, w_luse, w_branch;

   load_use_detect u_luse (
      .memread_ex (memread_ex),
      .rd_ex      (rd_ex),
      .rs_id      (rs_id),
      .rt_id      (rt_id),
      .luse       (w_luse)
   );

   assign w_dreq   = dREN_mem | dWEN_mem;
   assign w_dmiss  = w_dreq & ~dhit;
   assign w_branch = brtaken_ex | r_flush_pend;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= RUN;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_flush_pend <= w_flush_pend_nxt;
      end
   end

   always_comb begin
      pc_en            = 1'b0;
      ifid_en          = 1'b0;
      ifid_flush       = 1'b0;
      idex_en          = 1'b0;
      idex_flush       = 1'b0;
      exmem_en         = 1'b0;
      exmem_flush      = 1'b0;
      memwb_en         = 1'b0;
      halted           = 1'b0;
      w_state_nxt      = r_state;
      w_flush_pend_nxt = r_flush_pend;
      if (RST) begin
         ifid_flush       = 1'b1;
         idex_flush       = 1'b1;
         exmem_flush      = 1'b1;
         w_state_nxt      = RUN;
         w_flush_pend_nxt = 1'b0;
      end else if (r_state == HALT) begin
         halted = 1'b1;
      end else if (halt_wb) begin
         w_state_nxt = HALT;
      end else if (w_dmiss) begin
         // A branch resolved during the freeze is remembered and flushed on release
         w_state_nxt = DWAIT;
         if (brtaken_ex)
            w_flush_pend_nxt = 1'b1;
      end else begin
         if ((r_state == DWAIT) && w_dreq)
            w_state_nxt = RUN;
         if (w_branch) begin
            pc_en            = 1'b1;
            ifid_en          = 1'b1;
            ifid_flush       = 1'b1;
            idex_en          = 1'b1;
            idex_flush       = 1'b1;
            exmem_en         = 1'b1;
            memwb_en         = 1'b1;
            w_flush_pend_nxt = 1'b0;
         end else if (w_luse) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (!ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   word_t r_stall_cnt, r_flush_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_en && (r_state != HALT) && (r_stall_cnt != c_word_max))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (ifid_flush && (r_flush_cnt != c_word_max))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Randomized and directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     RST = 1'b1;
   logic     ihit = 1'b0, dhit = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0;
   logic     memread_ex = 1'b0, brtaken_ex = 1'b0, halt_wb = 1'b0;
   regbits_t rd_ex = '0, rs_id = '0, rt_id = '0;
   logic     pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic     exmem_en, exmem_flush, memwb_en, halted;
`ifdef HAZARD_CTRL_PERF_EN
   word_t    stall_cnt, flush_cnt;
`endif

   hazard_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .ihit        (ihit),
      .dhit        (dhit),
      .dREN_mem    (dREN_mem),
      .dWEN_mem    (dWEN_mem),
      .memread_ex  (memread_ex),
      .rd_ex       (rd_ex),
      .rs_id       (rs_id),
      .rt_id       (rt_id),
      .brtaken_ex  (brtaken_ex),
      .halt_wb     (halt_wb),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_flush  (ifid_flush),
      .idex_en     (idex_en),
      .idex_flush  (idex_flush),
      .exmem_en    (exmem_en),
      .exmem_flush (exmem_flush),
      .memwb_en    (memwb_en),
      .halted      (halted)
`ifdef HAZARD_CTRL_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          m_halted = 1'b0;
   bit          m_pend   = 1'b0;
   logic [31:0] m_stall  = '0;
   logic [31:0] m_flush  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en halted
   function automatic logic [8:0] outs();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
              exmem_en, exmem_flush, memwb_en, halted};
   endfunction

   // Expected outputs and the set of bits the rules pin down for this cycle
   task automatic model_outputs(output logic [8:0] e, output logic [8:0] c);
      bit dmiss = (dREN_mem | dWEN_mem) & ~dhit;
      bit luse  = memread_ex && (rd_ex != 0) && ((rd_ex == rs_id) || (rd_ex == rt_id));
      c = 9'h1FF;
      if (RST)                        e = 9'b0_0_1_0_1_0_1_0_0;
      else if (m_halted)              e = 9'b0_0_0_0_0_0_0_0_1;
      else if (halt_wb || dmiss)      e = 9'b0;
      else if (brtaken_ex || m_pend) begin
         e = 9'b1_0_1_0_1_1_0_1_0;
         c = 9'b1_0_1_0_1_1_1_1_1;
      end else if (luse) begin
         e = 9'b0_0_0_0_1_1_0_1_0;
         c = 9'b1_1_1_0_1_1_1_1_1;
      end else if (!ihit) begin
         e = 9'b0_0_1_1_0_1_0_1_0;
         c = 9'b1_0_1_1_1_1_1_1_1;
      end else                        e = 9'b1_1_0_1_0_1_0_1_0;
   endtask

   task automatic check_counters();
`ifdef HAZARD_CTRL_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
`endif
   endtask

   // One clock cycle with the inputs currently applied
   task automatic step(input string tag);
      logic [8:0] e, c;
      bit nh, np;
      bit dmiss;
      @(negedge CLK);
      model_outputs(e, c);
      check(tag, 32'(outs() & c), 32'(e & c));
      dmiss = (dREN_mem | dWEN_mem) & ~dhit;
      nh = m_halted;
      np = m_pend;
      if (!m_halted) begin
         if (halt_wb)                    nh = 1'b1;
         else if (dmiss)                 np = m_pend | brtaken_ex;
         else if (brtaken_ex || m_pend)  np = 1'b0;
         if (!e[8] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      if (e[6] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
      @(posedge CLK);
      #1;
      m_halted = nh;
      m_pend   = np;
      check_counters();
   endtask

   task automatic do_reset();
      logic [8:0] e, c;
      RST = 1'b1;
      m_halted = 1'b0;
      m_pend   = 1'b0;
      m_stall  = '0;
      m_flush  = '0;
      @(negedge CLK);
      model_outputs(e, c);
      check("reset_outs", 32'(outs()), 32'(e));
      check_counters();
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic quiet();
      ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
      memread_ex = 1'b0; brtaken_ex = 1'b0; halt_wb = 1'b0;
      rd_ex = '0; rs_id = '0; rt_id = '0;
   endtask

   initial begin
      quiet();
      @(posedge CLK);
      #1;
      do_reset();

      step("advance0");
      check("advance0_pc_en", 32'(pc_en), 32'd1);
      step("advance1");

      memread_ex = 1'b1; rd_ex = 5'd8; rs_id = 5'd8;
      step("luse");
      check("luse_pc_en", 32'(pc_en), 32'd0);
      memread_ex = 1'b0;
      step("luse_after");
      memread_ex = 1'b1; rd_ex = 5'd0; rs_id = 5'd0;
      step("luse_r0");
      check("luse_r0_pc_en", 32'(pc_en), 32'd1);
      quiet();

      dREN_mem = 1'b1; brtaken_ex = 1'b1;
      step("dmiss_c1");
      brtaken_ex = 1'b0;
      step("dmiss_c2");
      step("dmiss_c3");
      dhit = 1'b1;
      step("dwait_release");
      quiet();
      step("dwait_after");

      ihit = 1'b0; brtaken_ex = 1'b1;
      step("imiss_branch");
      brtaken_ex = 1'b0;
      step("imiss");

      quiet();
      halt_wb = 1'b1;
      step("halt_wb");
      halt_wb = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ihit = 1'($urandom); brtaken_ex = 1'($urandom); dREN_mem = 1'($urandom);
         halt_wb = 1'($urandom);
         step("halted");
         check("halted_flag", 32'(halted), 32'd1);
      end
      quiet();
      do_reset();
      step("post_halt");

`ifdef HAZARD_CTRL_PERF_EN
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i < 5; i++) step("perf_imiss");
      ihit = 1'b1; brtaken_ex = 1'b1;
      for (int i = 0; i < 2; i++) step("perf_branch");
      check("perf_stall5", stall_cnt, 32'd5);
      check("perf_flush7", flush_cnt, 32'd7);
      quiet();
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_cnt;
      m_stall = 32'hFFFF_FFFF;
      ihit = 1'b0;
      step("perf_sat");
      check("perf_sat_val", stall_cnt, 32'hFFFF_FFFF);
      quiet();
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
            do_reset();
         end
         ihit       = ($urandom_range(0, 3) != 0);
         dREN_mem   = ($urandom_range(0, 3) == 0);
         dWEN_mem   = ($urandom_range(0, 7) == 0);
         dhit       = 1'($urandom);
         memread_ex = ($urandom_range(0, 2) == 0);
         rd_ex      = 5'($urandom_range(0, 3));
         rs_id      = 5'($urandom_range(0, 3));
         rt_id      = 5'($urandom_range(0, 3));
         brtaken_ex = ($urandom_range(0, 5) == 0);
         halt_wb    = ($urandom_range(0, 99) == 0);
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
